rca_burst_accumulator: RTL and testbench
========================================

Name: rca_burst_accumulator

Overview:
- Sequential front/back stage wrapped around the team's N-bit unsigned ripple-carry adder.
- Accepts a burst of unsigned operands over a valid/ready stream.
- Drives the adder operands as running total + incoming operand, and registers the adder's Sum/Cout into the running total.
- Returns the final total with a sticky overflow flag over an output valid/ready handshake.

Parameters:
- N, 16, operand/sum width; must match the attached adder.
- CNT_W, 8, width of burst length and beat counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a burst; honoured only in IDLE.
- len  input  CNT_W  number of operands in the burst; sampled on accepted start.
- in_valid  input  1  operand available.
- in_data  input  N  unsigned operand.
- in_ready  output  1  block accepts operand this cycle.
- add_a  output  N  adder operand A = running total.
- add_b  output  N  adder operand B = in_data.
- add_cin  output  1  adder carry-in, tied 0.
- add_sum  input  N  adder Sum.
- add_cout  input  1  adder Cout (carry at MSB).
- out_valid  output  1  result available.
- out_sum  output  N  final total.
- out_ovf  output  1  sticky: at least one add produced carry-out.
- out_count  output  CNT_W  operands accepted in this burst.
- out_ready  input  1  downstream consumes result.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; acc, ovf, count and remaining cleared to 0.
  - in_ready=0, out_valid=0, out_sum=0, out_ovf=0, out_count=0, busy=0.
  - Reset mid-burst aborts the burst; partial results are discarded and never presented.
- Adder interface is combinational from registers: add_a=acc, add_b=in_data, add_cin=0 at all times.
- States IDLE, ACCUM, DONE:
  - IDLE: in_ready=0, out_valid=0.
    - start=1 with len!=0: acc<=0, ovf<=0, count<=0, remaining<=len, go to ACCUM.
    - start=1 with len==0: acc<=0, ovf<=0, count<=0, go to DONE.
  - ACCUM: in_ready=1.
    - Beat accepted when in_valid&&in_ready: acc<=add_sum, ovf<=ovf|add_cout, count<=count+1, remaining<=remaining-1.
    - When remaining==1 on an accepted beat, go to DONE.
    - in_valid=0 cycles are bubbles: no state change.
  - DONE: out_valid=1; out_sum=acc, out_ovf=ovf, out_count=count held stable.
    - out_valid&&out_ready: go to IDLE; out_valid drops next cycle.
- Latency:
  - out_valid asserts in the cycle after the last beat is accepted.
  - For len==0, out_valid asserts in the cycle after start.
  - Earliest new start is the cycle after the result handshake, i.e. once back in IDLE.
- start in ACCUM or DONE is ignored; len is not resampled.
- in_valid in IDLE or DONE is not accepted (in_ready=0).
- Arithmetic is unsigned, modulo 2^N; carry-out does not alter acc except under the optional feature.
- out_ovf is sticky for the whole burst; it clears only on the next accepted start or on reset.
- Maximum burst: len = 2^CNT_W-1; count cannot wrap.
- Outputs are registered state; out_* change only at clk edges.

Optional Feature:
- Macro RCA_ACC_SATURATE_EN.
- Defined: any accepted beat with add_cout=1 sets acc<=all ones instead of add_sum, and ovf<=1.
  - Subsequent beats keep acc at all ones: adding zero leaves all ones, adding nonzero carries out and clamps again.
- Undefined: acc wraps modulo 2^N; ovf still records carry.

Test Plan:
- N=16, start with len=3, beats 0x0001, 0x0002, 0x0003 back-to-back -> out_valid one cycle after 3rd beat; out_sum=0x0006, out_ovf=0, out_count=3.
- len=2, beats 0xFFFF, 0x0002 -> without macro: out_sum=0x0001, out_ovf=1. With RCA_ACC_SATURATE_EN: out_sum=0xFFFF, out_ovf=1.
- start with len=0 -> out_valid next cycle; out_sum=0, out_ovf=0, out_count=0; no beats accepted.
- len=2 with in_valid low 3 cycles between beats 0x1000, 0x0234 -> bubbles ignored; out_sum=0x1234, out_count=2.
- Result pending with out_ready=0 for 5 cycles while start=1 and in_valid=1 -> out_* stable, in_ready=0, busy=1, no new burst. out_ready=1 -> IDLE next cycle.
- rst=1 after first beat of a len=4 burst -> all outputs 0 next cycle, IDLE. Fresh len=1 burst with beat 0x00AA -> out_sum=0x00AA, out_ovf=0, out_count=1.

Source files
------------

// File: rtl/rca_burst_accumulator.sv
// rca_burst_accumulator: burst accumulator around an external N-bit RCA; define RCA_ACC_SATURATE_EN to clamp acc to all ones on carry-out
module rca_burst_accumulator #(
  parameter int N = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             in_ready,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  output logic             add_cin,
  input  logic [N-1:0]     add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  output logic [N-1:0]     out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count,
  input  logic             out_ready,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] acc, acc_nx;
  logic ovf;
  logic [CNT_W-1:0] count, remaining;
  logic beat, go;
  assign in_ready = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign beat = in_valid && in_ready;
  assign go = state == IDLE && start;
  assign add_a = acc;
  assign add_b = in_data;
  assign add_cin = 1'b0;
  assign out_sum = acc;
  assign out_ovf = ovf;
  assign out_count = count;
`ifdef RCA_ACC_SATURATE_EN
  assign acc_nx = add_cout ? '1 : add_sum;
`else
  assign acc_nx = add_sum;
`endif
  always_comb begin
    state_nx = state;
    state_nx = go ? ((len != '0) ? ACCUM : DONE) :
               (beat && remaining == CNT_W'(1)) ? DONE :
               (out_valid && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      ovf <= 1'b0;
      count <= '0;
      remaining <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        acc <= '0;
        ovf <= 1'b0;
        count <= '0;
        remaining <= len;
      end else if (beat) begin
        acc <= acc_nx;
        ovf <= ovf | add_cout;
        count <= count + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rca_burst_accumulator.sv
// tb_rca_burst_accumulator: directed self-checking bench with a behavioural ripple-carry adder
module tb_rca_burst_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] len = '0;
  logic in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic in_ready;
  logic [15:0] add_a, add_b, add_sum;
  logic add_cin, add_cout;
  logic out_valid, out_ovf, busy;
  logic [15:0] out_sum;
  logic [7:0] out_count;
  logic out_ready = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
  rca_burst_accumulator #(.N(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_sum(out_sum), .out_ovf(out_ovf),
    .out_count(out_count), .out_ready(out_ready), .busy(busy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic begin_burst(input logic [7:0] l);
    start = 1'b1;
    len = l;
    tick();
    start = 1'b0;
  endtask
  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic handshake;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, out_sum, out_ovf, out_count, busy} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {in_ready, out_valid, out_sum, out_ovf, out_count, busy});
    end
    vectors++;
    if (add_cin !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cin: got %b want 0", add_cin);
    end
  endtask
  task automatic test_basic;
    begin_burst(8'd3);
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_accum_state: got rdy=%b busy=%b ov=%b want 1 1 0", in_ready, busy, out_valid);
    end
    in_valid = 1'b1;
    in_data = 16'h0001;
    tick();
    vectors++;
    if (add_a !== 16'h0001) begin
      miscompares++;
      $display("FAIL basic_add_a: got %h want 0001", add_a);
    end
    in_data = 16'h0002;
    tick();
    in_data = 16'h0003;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_valid: got ov=%b rdy=%b want 1 0", out_valid, in_ready);
    end
    vectors++;
    if (out_sum !== 16'h0006 || out_ovf !== 1'b0 || out_count !== 8'd3) begin
      miscompares++;
      $display("FAIL basic_result: got %h/%b/%0d want 0006/0/3", out_sum, out_ovf, out_count);
    end
    handshake();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: got ov=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask
  task automatic test_overflow;
    logic [15:0] want;
`ifdef RCA_ACC_SATURATE_EN
    want = 16'hFFFF;
`else
    want = 16'h0001;
`endif
    begin_burst(8'd2);
    send(16'hFFFF);
    send(16'h0002);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== want || out_ovf !== 1'b1 || out_count !== 8'd2) begin
      miscompares++;
      $display("FAIL overflow_result: got %b/%h/%b/%0d want 1/%h/1/2", out_valid, out_sum, out_ovf, out_count, want);
    end
    handshake();
  endtask
  task automatic test_zero_len;
    in_valid = 1'b1;
    in_data = 16'h0F0F;
    begin_burst(8'd0);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_valid: got ov=%b rdy=%b want 1 0", out_valid, in_ready);
    end
    vectors++;
    if (out_sum !== 16'h0000 || out_ovf !== 1'b0 || out_count !== 8'd0) begin
      miscompares++;
      $display("FAIL zero_result: got %h/%b/%0d want 0000/0/0", out_sum, out_ovf, out_count);
    end
    in_valid = 1'b0;
    handshake();
  endtask
  task automatic test_bubbles;
    begin_burst(8'd2);
    send(16'h1000);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 8'd1) begin
        miscompares++;
        $display("FAIL bubble_hold: got rdy=%b ov=%b cnt=%0d want 1 0 1", in_ready, out_valid, out_count);
      end
    end
    send(16'h0234);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 16'h1234 || out_count !== 8'd2 || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL bubble_result: got %b/%h/%0d/%b want 1/1234/2/0", out_valid, out_sum, out_count, out_ovf);
    end
    handshake();
  endtask
  task automatic test_backpressure;
    begin_burst(8'd1);
    send(16'h0055);
    start = 1'b1;
    len = 8'd5;
    in_valid = 1'b1;
    in_data = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_sum !== 16'h0055 || out_count !== 8'd1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_stable: got ov=%b sum=%h cnt=%0d rdy=%b busy=%b want 1 0055 1 0 1", out_valid, out_sum, out_count, in_ready, busy);
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    handshake();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: got ov=%b busy=%b rdy=%b want 0 0 0", out_valid, busy, in_ready);
    end
  endtask
  task automatic test_reset_midburst;
    begin_burst(8'd4);
    send(16'h0100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, out_sum, out_ovf, out_count, busy} !== 28'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %h want 0", {in_ready, out_valid, out_sum, out_ovf, out_count, busy});
    end
    in_valid = 1'b1;
    in_data = 16'h1111;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0 || out_count !== 8'd0) begin
      miscompares++;
      $display("FAIL midreset_idle: got busy=%b cnt=%0d want 0 0", busy, out_count);
    end
    begin_burst(8'd1);
    send(16'h00AA);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 16'h00AA || out_ovf !== 1'b0 || out_count !== 8'd1) begin
      miscompares++;
      $display("FAIL midreset_fresh: got %b/%h/%b/%0d want 1/00aa/0/1", out_valid, out_sum, out_ovf, out_count);
    end
    handshake();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero_len();
    test_bubbles();
    test_backpressure();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
